// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle control FSM and the RV32I datapath.
// master = control FSM (drives strobes/selects), slave = datapath side.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       bcond;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_source;
    logic [2:0] state;
    logic       retire;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, mem_ready, bcond,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, retire, halted, illegal
    );

    modport slave (
        output opcode, mem_ready, bcond,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
               state, retire, halted, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I datapath: sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready and
// halts on ECALL.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t state_q, state_d;
    logic   halted_q, illegal_q;
    logic   known_op, is_load, is_store, is_link;

    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b;
    logic [2:0] alu_op;
    logic       pc_source, retire;

    // Opcode classification shared by next-state and output decode.
    always_comb begin
        is_load  = (bus.opcode == OP_LOAD);
        is_store = (bus.opcode == OP_STORE);
        is_link  = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
        case (bus.opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ECALL: known_op = 1'b1;
            default:                                     known_op = 1'b0;
        endcase
    end

    // State register and sticky halted/illegal flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) halted_q <= 1'b1;
            if (state_q == S_DECODE && !known_op) illegal_q <= 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_ECALL) state_d = S_HALT;
                else if (!known_op)         state_d = S_FETCH;
                else                        state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_load || is_store)            state_d = S_MEM;
                else if (bus.opcode == OP_BRANCH)   state_d = S_FETCH;
                else                                state_d = S_WB;
            end
            S_MEM:    if (bus.mem_ready) state_d = is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode from state and opcode (plus the memory handshake).
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 3'b010;
        pc_source  = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                if (!known_op) retire = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                case (bus.opcode)
                    OP_R:      begin alu_src_b = 2'd0; alu_op = 3'b000; end
                    OP_I:      alu_op = 3'b001;
                    OP_LOAD:   alu_op = 3'b110;
                    OP_STORE:  alu_op = 3'b010;
                    OP_BRANCH: begin
                        alu_src_b = 2'd0;
                        alu_op    = 3'b011;
                        pc_source = 1'b1;
                        pc_write  = bus.bcond;
                        retire    = 1'b1;
                    end
                    OP_LUI:    alu_op = 3'b100;
                    OP_AUIPC:  begin alu_src_a = 2'd2; alu_op = 3'b010; end
                    OP_JAL:    begin alu_src_a = 2'd2; alu_op = 3'b101; end
                    OP_JALR:   alu_op = 3'b111;
                    default:   alu_op = 3'b010;
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.mem_ready && is_store) retire = 1'b1;
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                if (is_load) begin
                    mem_to_reg = 2'd1;
                end else if (is_link) begin
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_source  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset moves the state to FETCH asynchronously, whose ready-qualified
    // strobes must still be suppressed until reset is released.
    assign bus.pc_write   = pc_write  & ~reset;
    assign bus.ir_write   = ir_write  & ~reset;
    assign bus.reg_write  = reg_write & ~reset;
    assign bus.mem_write  = mem_write & ~reset;
    assign bus.retire     = retire    & ~reset;
    assign bus.i_or_d     = i_or_d;
    assign bus.mem_read   = mem_read;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_source  = pc_source;
    assign bus.state      = state_q;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: opcode vector table, hand
// sequences for stalls/branches/JAL/illegal/ECALL/reset, and random
// instruction streams checked against a cycle-count reference model.
module tb_multicycle_control;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0] st;
        logic       pcw, irw, iord, mr, mw, rw, pcs, ret, hlt, ill;
        logic [1:0] m2r, a, b;
        logic [2:0] op;
    } obs_t;

    typedef struct {
        logic [6:0] opc;
        logic [1:0] a, b;
        logic [2:0] op;
        bit         has_wb;
        logic [1:0] m2r;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   ill_seen = 0;
    obs_t trace[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state;      o.pcw = bus.pc_write;  o.irw = bus.ir_write;
        o.iord = bus.i_or_d;   o.mr = bus.mem_read;   o.mw = bus.mem_write;
        o.rw = bus.reg_write;  o.pcs = bus.pc_source; o.ret = bus.retire;
        o.hlt = bus.halted;    o.ill = bus.illegal;   o.m2r = bus.mem_to_reg;
        o.a = bus.alu_src_a;   o.b = bus.alu_src_b;   o.op = bus.alu_op;
        return o;
    endfunction

    function automatic bit is_known(input logic [6:0] opc);
        return opc inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                           OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ECALL};
    endfunction

    // Runs one instruction from FETCH with sf fetch stalls and sm memory
    // stalls; expectations come from the instruction-class rules.
    task automatic run_instr(input string tag, input logic [6:0] opc,
                             input int sf, input int sm, input logic bc);
        int   exp_st[$];
        logic rdy[$];
        bit   ecall, known, is_ld, is_st, is_br, is_jl, has_wb, done;
        int   n_ret, n_irw, n_pcw, n_rw, n_mr, n_mw, n_halt_ok, n_halt_exp, st_k;
        obs_t o;
        ecall  = (opc == OP_ECALL);
        known  = is_known(opc);
        is_ld  = (opc == OP_LOAD);
        is_st  = (opc == OP_STORE);
        is_br  = (opc == OP_BRANCH);
        is_jl  = (opc == OP_JAL) || (opc == OP_JALR);
        has_wb = known && !ecall && !is_br && !is_st;

        for (int i = 0; i < sf; i++) begin exp_st.push_back(0); rdy.push_back(1'b0); end
        exp_st.push_back(0); rdy.push_back(1'b1);
        exp_st.push_back(1); rdy.push_back(1'($urandom));
        if (ecall) begin
            for (int i = 0; i < 12; i++) begin exp_st.push_back(5); rdy.push_back(1'($urandom)); end
        end else if (known) begin
            exp_st.push_back(2); rdy.push_back(1'($urandom));
            if (is_ld || is_st) begin
                for (int i = 0; i < sm; i++) begin exp_st.push_back(3); rdy.push_back(1'b0); end
                exp_st.push_back(3); rdy.push_back(1'b1);
            end
            if (has_wb) begin exp_st.push_back(4); rdy.push_back(1'($urandom)); end
        end

        trace.delete();
        done = 0;
        for (int k = 0; k < exp_st.size() + 4 && !done; k++) begin
            st_k = (k < exp_st.size()) ? exp_st[k] : -1;
            bus.opcode    = (st_k == 0) ? 7'($urandom) : opc;
            bus.bcond     = (st_k == 2) ? bc : 1'($urandom);
            bus.mem_ready = (k < rdy.size()) ? rdy[k] : 1'b1;
            @(negedge clk);
            o = sample();
            trace.push_back(o);
            done = ecall ? (k + 1 == exp_st.size()) : (o.ret === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!done) check({tag, ".timeout"}, 0, 1);

        check({tag, ".len"}, trace.size(), exp_st.size());
        for (int k = 0; k < exp_st.size() && k < trace.size(); k++)
            check($sformatf("%s.state[%0d]", tag, k), trace[k].st, exp_st[k]);

        n_ret = 0; n_irw = 0; n_pcw = 0; n_rw = 0; n_mr = 0; n_mw = 0;
        n_halt_ok = 0; n_halt_exp = 0;
        for (int k = 0; k < trace.size(); k++) begin
            n_ret += int'(trace[k].ret); n_irw += int'(trace[k].irw);
            n_pcw += int'(trace[k].pcw); n_rw  += int'(trace[k].rw);
            n_mr  += int'(trace[k].mr);  n_mw  += int'(trace[k].mw);
            if (k < exp_st.size() && exp_st[k] == 5) begin
                n_halt_exp++;
                if (trace[k].hlt && !(trace[k].pcw | trace[k].irw | trace[k].rw |
                                      trace[k].mw | trace[k].mr | trace[k].ret))
                    n_halt_ok++;
            end
        end
        check({tag, ".ill_in"}, trace[0].ill, ill_seen);
        check({tag, ".hlt_in"}, trace[0].hlt, 0);
        check({tag, ".retires"}, n_ret, ecall ? 0 : 1);
        if (!ecall) check({tag, ".ret_last"}, trace[trace.size()-1].ret, 1);
        check({tag, ".ir_writes"}, n_irw, 1);
        if (sf < trace.size()) check({tag, ".ir_at"}, trace[sf].irw, 1);
        check({tag, ".pc_writes"}, n_pcw, 1 + int'(is_br && bc) + int'(is_jl));
        check({tag, ".reg_writes"}, n_rw, int'(has_wb));
        check({tag, ".mem_reads"}, n_mr, sf + 1 + (is_ld ? sm + 1 : 0));
        check({tag, ".mem_writes"}, n_mw, is_st ? sm + 1 : 0);
        if (ecall) check({tag, ".halt_cycles"}, n_halt_ok, n_halt_exp);
        if (!known) ill_seen = 1;
    endtask

    vec_t vecs[$];
    logic [6:0] pool[11];

    initial begin
        vecs = '{
            '{OP_R,      2'd1, 2'd0, 3'b000, 1'b1, 2'd0},
            '{OP_I,      2'd1, 2'd2, 3'b001, 1'b1, 2'd0},
            '{OP_LOAD,   2'd1, 2'd2, 3'b110, 1'b1, 2'd1},
            '{OP_STORE,  2'd1, 2'd2, 3'b010, 1'b0, 2'd0},
            '{OP_BRANCH, 2'd1, 2'd0, 3'b011, 1'b0, 2'd0},
            '{OP_LUI,    2'd1, 2'd2, 3'b100, 1'b1, 2'd0},
            '{OP_AUIPC,  2'd2, 2'd2, 3'b010, 1'b1, 2'd0},
            '{OP_JAL,    2'd2, 2'd2, 3'b101, 1'b1, 2'd2},
            '{OP_JALR,   2'd1, 2'd2, 3'b111, 1'b1, 2'd2}
        };
        pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
                 OP_AUIPC, OP_JAL, OP_JALR, 7'b0000000, 7'b1111111};

        // Reset state, with mem_ready high to expose ungated FETCH strobes.
        reset = 1'b1; bus.opcode = '0; bus.mem_ready = 1'b1; bus.bcond = 1'b0;
        #2;
        check("rst.state", bus.state, 0);
        check("rst.strobes", {bus.pc_write, bus.ir_write, bus.reg_write,
                              bus.mem_write, bus.retire}, 0);
        check("rst.flags", {bus.halted, bus.illegal}, 0);
        @(posedge clk); #1; reset = 1'b0;

        // Opcode table, mem_ready high.
        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].opc, 0, 0, 1'b1);
            if (trace.size() > 2) begin
                check($sformatf("vec%0d.exec_a", i), trace[2].a, vecs[i].a);
                check($sformatf("vec%0d.exec_b", i), trace[2].b, vecs[i].b);
                check($sformatf("vec%0d.exec_op", i), trace[2].op, vecs[i].op);
            end
            if (vecs[i].has_wb)
                check($sformatf("vec%0d.wb_m2r", i), trace[trace.size()-1].m2r, vecs[i].m2r);
        end

        // Load with two memory stalls: MEM lasts 3 cycles, total 7.
        run_instr("ld_stall", OP_LOAD, 0, 2, 1'b0);
        for (int k = 3; k <= 5 && k < trace.size(); k++)
            check($sformatf("ld_stall.mem_req[%0d]", k), {trace[k].mr, trace[k].iord}, 2'b11);
        if (trace.size() > 6) check("ld_stall.wb_m2r", trace[6].m2r, 1);

        // Fetch stalls on an R-type.
        run_instr("r_fstall", OP_R, 3, 0, 1'b0);

        // Branch taken then not taken.
        run_instr("br_taken", OP_BRANCH, 0, 0, 1'b1);
        if (trace.size() > 2) check("br_taken.exec_pc", {trace[2].pcw, trace[2].pcs}, 2'b11);
        run_instr("br_not", OP_BRANCH, 0, 0, 1'b0);
        if (trace.size() > 2) check("br_not.exec_pcw", trace[2].pcw, 0);

        // JAL write-back.
        run_instr("jal", OP_JAL, 0, 0, 1'b0);
        if (trace.size() > 3)
            check("jal.wb", {trace[3].rw, trace[3].m2r, trace[3].pcw, trace[3].pcs}, 5'b1_10_1_1);

        // Unknown opcode; next instruction sees illegal set.
        run_instr("unk", 7'b0000000, 0, 0, 1'b0);
        run_instr("after_unk", OP_I, 0, 0, 1'b0);

        // Random instruction stream.
        for (int n = 0; n < 120; n++)
            run_instr($sformatf("rnd%0d", n), pool[$urandom_range(0, 10)],
                      $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

        // Reset asserted mid-MEM of a stalled store.
        bus.opcode = OP_STORE; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check("mid_store.state", bus.state, 3);
        check("mid_store.mem_write", bus.mem_write, 1);
        #2; reset = 1'b1; bus.mem_ready = 1'b1;
        #1;
        check("mid_store.rst_state", bus.state, 0);
        check("mid_store.rst_strobes", {bus.mem_write, bus.pc_write, bus.ir_write,
                                        bus.reg_write, bus.retire}, 0);
        check("mid_store.rst_flags", {bus.illegal, bus.halted}, 0);
        @(posedge clk); #1; reset = 1'b0; ill_seen = 0;
        run_instr("post_rst", OP_R, 0, 0, 1'b0);

        // ECALL halts for good.
        run_instr("ecall", OP_ECALL, 1, 0, 1'b0);

        // Only reset leaves HALT.
        reset = 1'b1;
        #1;
        check("halt_rst.state", bus.state, 0);
        check("halt_rst.halted", bus.halted, 0);
        @(posedge clk); #1; reset = 1'b0;
        run_instr("post_halt", OP_STORE, 0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
